// File: rtl/wb_trace_tx.sv
// Write-back trace transmitter: buffers register-file writes and streams each as a framed byte sequence.
// Optional build macro TRACE_CHECKSUM_EN appends an XOR checksum byte to every frame.
module wb_trace_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbValid,
    input  logic [4:0]        wbAddr,
    input  logic [31:0]       wbData,
    output logic [7:0]        byteOut,
    output logic              byteValid,
    input  logic              byteReady,
    output logic [ADDR_W:0]   fifoCount,
    output logic              overflow,
    output logic              busy
);

`ifdef TRACE_CHECKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif
    localparam logic [2:0]      LAST_IDX   = 3'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      SYNC_BYTE  = 8'hA5;

    typedef enum logic {
        IDLE,
        SEND
    } stateT;

    // FIFO storage: {wbAddr, wbData} per entry
    logic [36:0]       fifoMem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [ADDR_W:0]   countReg;
    logic              overflowReg;

    stateT             state;
    logic [36:0]       entryReg;
    logic [2:0]        idxReg;
    logic [7:0]        byteOutReg;
    logic              byteValidReg;

    logic              pushReq;
    logic              fifoFull;
    logic              pushEn;
    logic              popEn;
    logic [2:0]        idxNext;
    logic [FRAME_LEN-1:0][7:0] frameBytes;

    assign pushReq  = wbValid && (wbAddr != 5'd0);
    assign fifoFull = (countReg == FULL_COUNT);
    assign pushEn   = pushReq && !fifoFull;
    assign popEn    = (state == IDLE) && (countReg != '0);
    assign idxNext  = idxReg + 3'd1;

    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem[wrPtr] <= {wbAddr, wbData};
        end
    end

    // Registered read of the FIFO head; this register is the frame source.
    always_ff @(posedge clk) begin
        if (popEn) begin
            entryReg <= fifoMem[rdPtr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
            // Full test is on the pre-edge count, so a same-edge pop does not rescue the push.
            if (pushReq && fifoFull) begin
                overflowReg <= 1'b1;
            end
        end
    end

    assign frameBytes[0] = SYNC_BYTE;
    assign frameBytes[1] = {3'b000, entryReg[36:32]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gDataBytes
            assign frameBytes[2 + gi] = entryReg[31 - 8 * gi -: 8];
        end
    endgenerate

`ifdef TRACE_CHECKSUM_EN
    assign frameBytes[6] = frameBytes[1] ^ frameBytes[2] ^ frameBytes[3]
                         ^ frameBytes[4] ^ frameBytes[5];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idxReg       <= '0;
            byteOutReg   <= 8'h00;
            byteValidReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (popEn) begin
                        state        <= SEND;
                        idxReg       <= '0;
                        byteOutReg   <= SYNC_BYTE;
                        byteValidReg <= 1'b1;
                    end
                end
                SEND: begin
                    if (byteReady) begin
                        if (idxReg == LAST_IDX) begin
                            state        <= IDLE;
                            idxReg       <= '0;
                            byteOutReg   <= 8'h00;
                            byteValidReg <= 1'b0;
                        end else begin
                            idxReg     <= idxNext;
                            byteOutReg <= frameBytes[idxNext];
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    byteValidReg <= 1'b0;
                end
            endcase
        end
    end

    assign byteOut   = byteOutReg;
    assign byteValid = byteValidReg;
    assign fifoCount = countReg;
    assign overflow  = overflowReg;
    assign busy      = (state == SEND) || (countReg != '0);

endmodule
